usb_frame_parser: RTL

//  Sits between the FT245 wrapper's RX simple interface and the sample FIFO.

---
 rtl/usb_frame_parser_pkg.sv | 23 ++
 rtl/usb_frame_parser_inactivity_timer.sv | 30 +++
 rtl/usb_frame_parser.sv | 130 +++++++++++++
 3 files changed

// File: rtl/usb_frame_parser_pkg.sv
// Shared constants, state encoding and helpers for the host frame parser.
// The modulator config decode imports the same frame type codes.
package usb_frame_parser_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
    localparam logic [7:0] TYPE_SAMPLE      = 8'h01;
    localparam logic [7:0] TYPE_CONFIG      = 8'h02;
    localparam int         N_CFG_DEF        = 4;
    localparam int         TIMEOUT_CLKS_DEF = 1_280_000;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_TYPE    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/usb_frame_parser_inactivity_timer.sv
// Idle-cycle counter: restarts on clear or while not running, flags expiry
// after TIMEOUT_CLKS running cycles with no clear.
module inactivity_timer #(
    parameter int TIMEOUT_CLKS = 1_280_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear || !run) begin
            count_q <= '0;
        end else if (!expired) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = run && (count_q == LIMIT);

endmodule

// File: rtl/usb_frame_parser.sv
// Parses SYNC/TYPE/LEN/payload/CHK frames from the FT245 RX stream, cuts
// sample payload through to the FIFO and commits checked config frames.
module usb_frame_parser
    import usb_frame_parser_pkg::*;
#(
    parameter logic [7:0]         SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int                 N_CFG        = N_CFG_DEF,
    parameter logic [8*N_CFG-1:0] CFG_RST      = 'h0000_0104,
    parameter int                 TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data_si,
    input  logic               rx_valid_si,
    output logic               rx_ready_si,
    output logic [7:0]         fifo_wr_data,
    output logic               fifo_wr_en,
    input  logic               fifo_full,
    output logic [8*N_CFG-1:0] cfg_regs,
    output logic               frame_ok,
    output logic               frame_err,
    output logic [7:0]         err_cnt,
    output state_t             state_dbg
);

    state_t             state_q, state_d;
    logic [7:0]         type_q, len_q, cnt_q, chk_q;
    logic [8*N_CFG-1:0] shadow_q;
    logic               xfer, expired, is_sample_payload, frame_valid;
    logic               ok_d, err_d, commit;

    // rx handshake: a byte moves on every clk edge where rx_valid_si & rx_ready_si;
    // ready only drops to backpressure sample payload while the FIFO is full.
    assign is_sample_payload = (state_q == ST_PAYLOAD) && (type_q == TYPE_SAMPLE);
    assign rx_ready_si       = !(is_sample_payload && fifo_full);
    assign xfer              = rx_valid_si && rx_ready_si;
    assign fifo_wr_en        = xfer && is_sample_payload;
    assign fifo_wr_data      = rx_data_si;
    assign frame_valid       = (type_q == TYPE_SAMPLE) ||
                               ((type_q == TYPE_CONFIG) && (len_q == 8'(N_CFG)));
    assign state_dbg         = state_q;

    inactivity_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (xfer),
        .run     (state_q != ST_HUNT),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        commit  = 1'b0;
        if (xfer) begin
            case (state_q)
                ST_HUNT:    if (rx_data_si == SYNC_BYTE) state_d = ST_TYPE;
                ST_TYPE:    state_d = ST_LEN;
                ST_LEN:     state_d = (rx_data_si == 8'd0) ? ST_CHK : ST_PAYLOAD;
                ST_PAYLOAD: if (cnt_q == len_q - 8'd1) state_d = ST_CHK;
                ST_CHK: begin
                    state_d = ST_HUNT;
                    if ((rx_data_si == chk_q) && frame_valid) begin
                        ok_d   = 1'b1;
                        commit = (type_q == TYPE_CONFIG);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default:    state_d = ST_HUNT;
            endcase
        end else if (expired && (state_q != ST_HUNT)) begin
            // A transfer in the expiry cycle takes priority over the timeout.
            state_d = ST_HUNT;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            type_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            chk_q     <= '0;
            shadow_q  <= CFG_RST;
            cfg_regs  <= CFG_RST;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (xfer) begin
                case (state_q)
                    ST_TYPE: begin
                        type_q <= rx_data_si;
                        chk_q  <= rx_data_si;
                    end
                    ST_LEN: begin
                        len_q <= rx_data_si;
                        chk_q <= chk_q ^ rx_data_si;
                        cnt_q <= '0;
                    end
                    ST_PAYLOAD: begin
                        chk_q <= chk_q ^ rx_data_si;
                        cnt_q <= cnt_q + 8'd1;
                        if (type_q == TYPE_CONFIG) begin
                            for (int i = 0; i < N_CFG; i++) begin
                                if (cnt_q == 8'(i)) shadow_q[8*i +: 8] <= rx_data_si;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (commit) cfg_regs <= shadow_q;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            if (err_d) err_cnt <= sat_inc8(err_cnt);
        end
    end

endmodule
